// File: rtl/aes_128_pkg.sv
// Shared types and constants for the AES-128 request scheduler.
package aes_128_pkg;
    localparam int BLOCK_W          = 128;
    localparam int ISSUE_GAP_DEF    = 4;
    localparam int MAX_INFLIGHT_DEF = 8;

    // Identifies which requester a block came from; doubles as the tag FIFO payload.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;
endpackage

// File: rtl/aes_128_tag_fifo.sv
// Tag FIFO: remembers the requester of each block in flight through the core.
// The caller guarantees push only when not full and pop only when not empty.
module aes_128_tag_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          kill_n,
    input  logic          push,
    input  logic          push_data,
    input  logic          pop,
    output logic          head,
    output logic [CW-1:0] count
);
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head = mem[rd_ptr];

    // Storage, power-of-two pointers that wrap naturally, and occupancy count.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/aes_128_sched.sv
// Two-requester round-robin scheduler in front of a pipelined AES-128 core.
// Throttles issue by a minimum gap, tracks in-flight requester tags, and
// routes core results back to the requester that submitted each block.
module aes_128_sched
    import aes_128_pkg::*;
#(
    parameter int ISSUE_GAP    = ISSUE_GAP_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic               clk,
    input  logic               kill_n,
    input  logic [BLOCK_W-1:0] req0_data,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [BLOCK_W-1:0] req1_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               key_ready,
    output logic [BLOCK_W-1:0] core_in_data,
    output logic               core_in_en,
    input  logic [BLOCK_W-1:0] core_out_data,
    input  logic               core_out_en,
    output logic [BLOCK_W-1:0] resp0_data,
    output logic               resp0_valid,
    output logic [BLOCK_W-1:0] resp1_data,
    output logic               resp1_valid,
    output logic               busy,
    output logic               err_orphan
);
    localparam int             CW       = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(MAX_INFLIGHT);
    localparam logic [3:0]     GAP_LOAD = 4'(ISSUE_GAP - 1);

    logic [3:0]    gap_cnt;
    req_id_t       prio;        // requester that wins when both are valid
    logic [CW-1:0] tag_count;
    logic          tag_head;
    logic          issue_ok;
    logic          grant1;
    logic          handshake;
    logic          pop;
    logic          orphan;

    assign issue_ok  = key_ready && (gap_cnt == 4'd0) && (tag_count < FULL_CNT);
    assign grant1    = req1_valid && (!req0_valid || prio == REQ1);
    // Readies are forced low while reset is held so nothing is accepted then.
    assign req0_ready = kill_n && issue_ok && req0_valid && !grant1;
    assign req1_ready = kill_n && issue_ok && grant1;
    assign handshake  = req0_ready || req1_ready;
    assign pop        = core_out_en && (tag_count != '0);
    assign orphan     = core_out_en && (tag_count == '0);
    assign busy       = (tag_count != '0);

    aes_128_tag_fifo #(.DEPTH(MAX_INFLIGHT)) u_tag_fifo (
        .clk       (clk),
        .kill_n    (kill_n),
        .push      (handshake),
        .push_data (grant1),
        .pop       (pop),
        .head      (tag_head),
        .count     (tag_count)
    );

    // Issue side: register accepted block, throttle gap, rotate priority.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            core_in_en   <= 1'b0;
            core_in_data <= '0;
            gap_cnt      <= 4'd0;
            prio         <= REQ0;
        end else begin
            core_in_en <= handshake;
            if (handshake) begin
                core_in_data <= grant1 ? req1_data : req0_data;
                gap_cnt      <= GAP_LOAD;
                prio         <= grant1 ? REQ0 : REQ1;
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    // Return side: route core results by the head tag; flag results with no owner.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_data  <= '0;
            resp1_data  <= '0;
            err_orphan  <= 1'b0;
        end else begin
            resp0_valid <= pop && (tag_head == REQ0);
            resp1_valid <= pop && (tag_head == REQ1);
            if (pop && tag_head == REQ0)
                resp0_data <= core_out_data;
            if (pop && tag_head == REQ1)
                resp1_data <= core_out_data;
            if (orphan)
                err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_128_sched.sv
// Scoreboard bench for aes_128_sched with default parameters (gap 4, depth 8).
// Directed cycles carry hand-chosen expected ready patterns; accepted blocks and
// returned results are queued and popped by monitors when the DUT presents them.
module tb_aes_128_sched;
    logic         clk = 1'b0;
    logic         kill_n = 1'b0;
    logic [127:0] req0_data = '0, req1_data = '0, core_out_data = '0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0, key_ready = 1'b0, core_out_en = 1'b0;
    logic         req0_ready, req1_ready, core_in_en, resp0_valid, resp1_valid, busy, err_orphan;
    logic [127:0] core_in_data, resp0_data, resp1_data;

    int n_checks = 0;
    int n_fail   = 0;

    bit           tagq[$];
    logic [127:0] issq[$];
    logic [128:0] respq[$];
    bit           p_in = 0, p_r0 = 0, p_r1 = 0;

    aes_128_sched dut (
        .clk(clk), .kill_n(kill_n),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .key_ready(key_ready),
        .core_in_data(core_in_data), .core_in_en(core_in_en),
        .core_out_data(core_out_data), .core_out_en(core_out_en),
        .resp0_data(resp0_data), .resp0_valid(resp0_valid),
        .resp1_data(resp1_data), .resp1_valid(resp1_valid),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue monitor: each core_in_en must carry the next accepted block.
    always @(negedge clk) begin
        if (kill_n && core_in_en) begin
            if (issq.size() == 0) check1("core_in_unexpected", core_in_en, 1'b0);
            else check128("core_in_data", core_in_data, issq.pop_front());
        end
    end

    // Response monitor: each result must appear on the right channel with the right data.
    always @(negedge clk) begin
        logic [128:0] e;
        if (kill_n && resp0_valid && resp1_valid) check1("resp_both_valid", resp1_valid, 1'b0);
        if (kill_n && resp0_valid) begin
            if (respq.size() == 0) check1("resp0_unexpected", resp0_valid, 1'b0);
            else begin
                e = respq.pop_front();
                check1("resp0_route", 1'b0, e[128]);
                check128("resp0_data", resp0_data, e[127:0]);
            end
        end
        if (kill_n && resp1_valid) begin
            if (respq.size() == 0) check1("resp1_unexpected", resp1_valid, 1'b0);
            else begin
                e = respq.pop_front();
                check1("resp1_route", 1'b1, e[128]);
                check128("resp1_data", resp1_data, e[127:0]);
            end
        end
    end

    // One clock of stimulus with the expected ready pattern for that cycle.
    task automatic cycle(input bit v0, input logic [127:0] d0, input bit v1, input logic [127:0] d1,
                         input bit kr, input bit ce, input logic [127:0] cd, input bit e0, input bit e1);
        bit id;
        @(negedge clk);
        req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
        key_ready = kr; core_out_en = ce; core_out_data = cd;
        #1;
        check1("core_in_en", core_in_en, p_in);
        check1("resp0_valid", resp0_valid, p_r0);
        check1("resp1_valid", resp1_valid, p_r1);
        check1("busy", busy, tagq.size() != 0);
        check1("req0_ready", req0_ready, e0);
        check1("req1_ready", req1_ready, e1);
        p_r0 = 0; p_r1 = 0;
        if (ce && tagq.size() != 0) begin
            id = tagq.pop_front();
            respq.push_back({id, cd});
            if (id) p_r1 = 1; else p_r0 = 1;
        end
        p_in = e0 | e1;
        if (e0) begin tagq.push_back(1'b0); issq.push_back(d0); end
        if (e1) begin tagq.push_back(1'b1); issq.push_back(d1); end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, 1, 0, '0, 0, 0);
    endtask

    task automatic ret(input logic [127:0] cd);
        cycle(0, '0, 0, '0, 1, 1, cd, 0, 0);
    endtask

    // Assert reset with a requester pending; everything must read zero at once.
    task automatic do_kill();
        @(negedge clk);
        req0_valid = 1; req1_valid = 1; key_ready = 1; core_out_en = 0;
        kill_n = 0;
        #1;
        check1("rst_core_in_en", core_in_en, 1'b0);
        check128("rst_core_in_data", core_in_data, '0);
        check1("rst_resp0_valid", resp0_valid, 1'b0);
        check1("rst_resp1_valid", resp1_valid, 1'b0);
        check128("rst_resp0_data", resp0_data, '0);
        check128("rst_resp1_data", resp1_data, '0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err_orphan", err_orphan, 1'b0);
        check1("rst_req0_ready", req0_ready, 1'b0);
        check1("rst_req1_ready", req1_ready, 1'b0);
        check1("rst_issue_drained", issq.size() == 0, 1'b1);
        check1("rst_resp_drained", respq.size() == 0, 1'b1);
        tagq.delete(); issq.delete(); respq.delete();
        p_in = 0; p_r0 = 0; p_r1 = 0;
        @(negedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        kill_n = 1;
    endtask

    localparam logic [127:0] D_SINGLE = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        logic [127:0] d;

        // Reset state.
        do_kill();

        // Single requester: ready same cycle, issue next cycle, result to resp0.
        cycle(1, D_SINGLE, 0, '0, 1, 0, '0, 1, 0);
        idle(3);
        ret(128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a);
        idle(2);

        // Two tags in flight (priority now with req1), then reset mid-flight.
        cycle(1, 128'hA0, 1, 128'hB0, 1, 0, '0, 0, 1);
        for (int i = 1; i < 4; i++) cycle(1, 128'hA0, 0, '0, 1, 0, '0, 0, 0);
        cycle(1, 128'hA0, 0, '0, 1, 0, '0, 1, 0);
        idle(3);
        do_kill();

        // Orphan after reset discarded the tags: no response, sticky error.
        ret(128'hDEAD);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check1("err_orphan_sticky", err_orphan, 1'b1);
        end
        do_kill();

        // Contention: priority back on req0, grants 0,1,0,1 every 4 cycles.
        for (int i = 0; i < 16; i++) begin
            d = {4{32'(i) ^ 32'h1000_0000}};
            cycle(1, d, 1, ~d, 1, 0, '0, (i % 8) == 0, (i % 8) == 4);
        end
        idle(3);
        for (int i = 0; i < 4; i++) ret({4{32'(i) ^ 32'hC0DE_0000}});
        idle(2);

        // Full: 8 issues fill the FIFO; 9th blocked even with a same-cycle pop.
        for (int i = 0; i < 32; i++)
            cycle(1, {4{32'(i) ^ 32'h2000_0000}}, 0, '0, 1, 0, '0, (i % 4) == 0, 0);
        check1("full_busy", busy, 1'b1);
        cycle(1, 128'hF00D, 0, '0, 1, 1, 128'hE0, 0, 0);
        cycle(1, 128'hF00D, 0, '0, 1, 0, '0, 1, 0);
        for (int i = 0; i < 8; i++) ret({4{32'(i) ^ 32'hE000_0000}});
        idle(2);

        // key_ready low with 3 in flight: no grants, results still route.
        for (int i = 0; i < 9; i++)
            cycle(0, '0, 1, {4{32'(i) ^ 32'h3000_0000}}, 1, 0, '0, 0, (i % 4) == 0);
        idle(2);
        for (int i = 0; i < 6; i++) cycle(1, 128'h1, 1, 128'h2, 0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check1("kr_busy_before_pop", busy, 1'b1);
            cycle(1, 128'h1, 1, 128'h2, 0, 1, {4{32'(i) ^ 32'h5A00_0000}}, 0, 0);
        end
        cycle(0, '0, 0, '0, 0, 0, '0, 0, 0);
        check1("kr_busy_fall", busy, 1'b0);
        idle(2);
        check1("err_orphan_clear", err_orphan, 1'b0);

        // Orphan on an idle FIFO sets the sticky error and produces no response.
        ret(128'hBAD);
        idle(3);
        check1("orphan_err", err_orphan, 1'b1);

        check1("issue_queue_empty", issq.size() == 0, 1'b1);
        check1("resp_queue_empty", respq.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_128_sched.md
AES_128_SCHED -- requirements
Module: aes_128_sched

Interface
REQ-001 SHALL have parameter ISSUE_GAP, default 4: minimum clk cycles between successive core_in_en pulses (range 1..15).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 8: depth of the tag FIFO (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port kill_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports req0_data / req1_data, input, 128: plaintext block from requester 0 / 1.
REQ-006 SHALL have ports req0_valid / req1_valid, input, 1: requester has a block pending.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1: block accepted this cycle.
REQ-008 SHALL have port key_ready, input, 1: key RAM holds a valid schedule.
REQ-009 SHALL have ports core_in_data, output, 128, and core_in_en, output, 1: issue to the AES core.
REQ-010 SHALL have ports core_out_data, input, 128, and core_out_en, input, 1: AES core result.
REQ-011 SHALL have ports resp0_data / resp1_data, output, 128, and resp0_valid / resp1_valid, output, 1: routed results.
REQ-012 SHALL have port busy, output, 1: high while tag FIFO count is nonzero.
REQ-013 SHALL have port err_orphan, output, 1: sticky, core_out_en seen with empty tag FIFO.

Function
REQ-014 SHALL define issue_ok = key_ready AND gap counter == 0 AND tag count < MAX_INFLIGHT.
REQ-015 SHALL assert reqN_ready combinationally only when issue_ok, reqN_valid and reqN is granted; at most one ready per cycle.
REQ-016 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; with one valid, grant it; priority pointer updates only on a handshake.
REQ-017 SHALL register the granted data: core_in_en high for exactly one cycle, the cycle after the handshake, with core_in_data = accepted block.
REQ-018 SHALL load the gap counter with ISSUE_GAP-1 on each handshake and decrement to 0 saturating; ISSUE_GAP=1 permits back-to-back issue.
REQ-019 SHALL push the granted requester ID into the tag FIFO on each handshake.
REQ-020 SHALL, on core_out_en, pop the FIFO head and drive respID_valid high for one cycle, the next cycle, with respID_data = core_out_data; the other resp_valid stays low.
REQ-021 SHALL allow push and pop in the same cycle; count unchanged; the full check uses the count before the pop (no push when count == MAX_INFLIGHT).
REQ-022 SHALL, on core_out_en with count == 0, ignore the data, not pulse either resp_valid, and set err_orphan until reset.
REQ-023 SHALL, when key_ready drops, stop new grants immediately; in-flight blocks still route normally.
REQ-024 SHALL hold resp*_data at its last value when resp*_valid is low.
REQ-025 SHALL wrap FIFO pointers modulo MAX_INFLIGHT.

Reset
REQ-026 SHALL, on kill_n low, asynchronously clear: core_in_en, resp0_valid, resp1_valid, busy, err_orphan, all ready outputs, gap counter, FIFO pointers/count, and set the priority pointer to requester 0.
REQ-027 SHALL clear core_in_data, resp0_data and resp1_data to 0 on reset.
REQ-028 SHALL discard in-flight tags on reset mid-operation; later core_out_en pulses follow REQ-022.

Structure
REQ-029 SHALL place the requester-ID type, the 128-bit block width constant and the defaults for ISSUE_GAP and MAX_INFLIGHT in a shared package aes_128_pkg.
REQ-030 SHALL implement the tag FIFO as sub-module aes_128_tag_fifo (parameterised depth, 1-bit data, count output).

Verification
REQ-031 Single requester: req0 valid, data 0x00112233_44556677_8899aabb_ccddeeff, key_ready=1 -> req0_ready the same cycle, core_in_en one cycle later with that data; core_out_en -> resp0_valid next cycle.
REQ-032 Contention: both valid continuously, ISSUE_GAP=4 -> grants alternate 0,1,0,1 at 4-cycle spacing; results return in order to resp0, resp1, resp0, resp1.
REQ-033 Full: MAX_INFLIGHT=8, 8 issues with no core_out_en -> 9th blocked (ready low); a core_out_en in the same cycle still blocks; grant resumes the cycle after.
REQ-034 key_ready low with 3 in flight -> no ready asserted; 3 core_out_en pulses -> 3 correct resp pulses; busy falls after the last.
REQ-035 Orphan: core_out_en with an empty FIFO -> no resp_valid, err_orphan=1 and held until kill_n low.
REQ-036 Reset mid-flight: kill_n low with 2 tags queued -> all outputs 0 immediately; priority on requester 0 after release.
